// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters, porch/sync region
// decode, and a gated delay line that aligns sync/blank with a downstream pipeline.
module video_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int SYNC_DLY    = 2,
  parameter int PIXEL_CTR_W = 10,
  parameter int LINE_CTR_W  = 9
) (
  input  logic                   rfr_clk,
  input  logic                   reset_n,
  input  logic                   en,
  output logic [PIXEL_CTR_W:0]   pixel_cnt,
  output logic [LINE_CTR_W:0]    line_cnt,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   video_on,
  output logic                   frame_start,
  output logic                   line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [PIXEL_CTR_W:0] pix_t;
  typedef logic [LINE_CTR_W:0]  lin_t;

  localparam pix_t H_LAST = pix_t'(H_TOTAL - 1);
  localparam lin_t V_LAST = lin_t'(V_TOTAL - 1);

  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYN, HS_BP} h_state_t;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYN, VS_BP} v_state_t;

  typedef struct packed {
    logic h;
    logic v;
    logic on;
  } raw_t;

  localparam raw_t RAW_IDLE = '{h: ~SYNC_POL, v: ~SYNC_POL, on: 1'b0};

  h_state_t h_state;
  v_state_t v_state;
  raw_t     raw;
  logic     h_last;
  logic     v_last;

  assign h_last = (pixel_cnt == H_LAST);
  assign v_last = (line_cnt == V_LAST);

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_cnt <= '0;
      line_cnt  <= '0;
    end else if (en) begin
      if (h_last) begin
        pixel_cnt <= '0;
        line_cnt  <= v_last ? '0 : line_cnt + lin_t'(1);
      end else begin
        pixel_cnt <= pixel_cnt + pix_t'(1);
      end
    end
  end

  // Region decode is done in int so a zero back porch cannot overflow the bounds.
  always_comb begin
    h_state = HS_BP;
    if (int'(pixel_cnt) < H_ACTIVE)                      h_state = HS_ACT;
    else if (int'(pixel_cnt) < H_ACTIVE + H_FP)          h_state = HS_FP;
    else if (int'(pixel_cnt) < H_ACTIVE + H_FP + H_SYNC) h_state = HS_SYN;
  end

  always_comb begin
    v_state = VS_BP;
    if (int'(line_cnt) < V_ACTIVE)                      v_state = VS_ACT;
    else if (int'(line_cnt) < V_ACTIVE + V_FP)          v_state = VS_FP;
    else if (int'(line_cnt) < V_ACTIVE + V_FP + V_SYNC) v_state = VS_SYN;
  end

  always_comb begin
    raw.h  = (h_state == HS_SYN) ? SYNC_POL : ~SYNC_POL;
    raw.v  = (v_state == VS_SYN) ? SYNC_POL : ~SYNC_POL;
    raw.on = (h_state == HS_ACT) && (v_state == VS_ACT);
  end

  assign line_start  = en && (pixel_cnt == '0);
  assign frame_start = line_start && (line_cnt == '0);

  generate
    if (SYNC_DLY == 0) begin : g_nodly
      // Counters read zero in reset, which decodes as visible; force idle levels.
      assign h_sync   = reset_n ? raw.h  : ~SYNC_POL;
      assign v_sync   = reset_n ? raw.v  : ~SYNC_POL;
      assign video_on = reset_n ? raw.on : 1'b0;
    end else begin : g_dly
      raw_t [SYNC_DLY-1:0] dly_pipe;

      always_ff @(posedge rfr_clk or negedge reset_n) begin
        if (!reset_n) begin
          dly_pipe <= {SYNC_DLY{RAW_IDLE}};
        end else if (en) begin
          dly_pipe[0] <= raw;
          for (int i = 1; i < SYNC_DLY; i++) dly_pipe[i] <= dly_pipe[i-1];
        end
      end

      assign h_sync   = dly_pipe[SYNC_DLY-1].h;
      assign v_sync   = dly_pipe[SYNC_DLY-1].v;
      assign video_on = dly_pipe[SYNC_DLY-1].on;
    end
  endgenerate

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized-enable bench for video_timing_gen: three configurations share one
// stimulus; expected outputs come from the enabled-cycle index via plain arithmetic.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  // u0: small raster, delay 2, active-low sync
  logic [4:0] p0; logic [3:0] l0; logic hs0, vs0, on0, fs0, ls0;
  // u1: small raster, no delay, active-high sync
  logic [4:0] p1; logic [3:0] l1; logic hs1, vs1, on1, fs1, ls1;
  // u2: default 640x480 timing
  logic [10:0] p2; logic [9:0] l2; logic hs2, vs2, on2, fs2, ls2;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .SYNC_DLY(2), .PIXEL_CTR_W(4), .LINE_CTR_W(3)
  ) u0 (
    .rfr_clk(clk), .reset_n(reset_n), .en(en), .pixel_cnt(p0), .line_cnt(l0),
    .h_sync(hs0), .v_sync(vs0), .video_on(on0), .frame_start(fs0), .line_start(ls0)
  );

  video_timing_gen #(
    .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .SYNC_POL(1'b1), .SYNC_DLY(0), .PIXEL_CTR_W(4), .LINE_CTR_W(3)
  ) u1 (
    .rfr_clk(clk), .reset_n(reset_n), .en(en), .pixel_cnt(p1), .line_cnt(l1),
    .h_sync(hs1), .v_sync(vs1), .video_on(on1), .frame_start(fs1), .line_start(ls1)
  );

  video_timing_gen u2 (
    .rfr_clk(clk), .reset_n(reset_n), .en(en), .pixel_cnt(p2), .line_cnt(l2),
    .h_sync(hs2), .v_sync(vs2), .video_on(on2), .frame_start(fs2), .line_start(ls2)
  );

  typedef struct {
    int pc;
    int lc;
    bit hs;
    bit vs;
    bit on;
    bit ls;
    bit fs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int failures = 0;
  int k = 0;   // enabled edges since reset release

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Outputs seen after kk enabled edges; sync/blank lag the raster by dly edges.
  function automatic exp_t model(int kk, bit e, bit rst, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, bit pol, int dly);
    exp_t r;
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    int j, pj, lj;
    r.pc = kk % ht;
    r.lc = (kk / ht) % vt;
    r.ls = e && (r.pc == 0);
    r.fs = r.ls && (r.lc == 0);
    if (rst || kk < dly) begin
      r.hs = !pol;
      r.vs = !pol;
      r.on = 1'b0;
    end else begin
      j  = kk - dly;
      pj = j % ht;
      lj = (j / ht) % vt;
      r.hs = (pj >= ha + hf && pj < ha + hf + hsw) ? pol : !pol;
      r.vs = (lj >= va + vf && lj < va + vf + vsw) ? pol : !pol;
      r.on = (pj < ha) && (lj < va);
    end
    return r;
  endfunction

  task automatic push_all();
    bit rst = !reset_n;
    q0.push_back(model(k, en, rst, 8, 2, 3, 3, 6, 1, 2, 2, 1'b0, 2));
    q1.push_back(model(k, en, rst, 5, 1, 2, 2, 4, 1, 1, 2, 1'b1, 0));
    q2.push_back(model(k, en, rst, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2));
  endtask

  // One cycle of stimulus: inputs change 1 time unit after the rising edge.
  task automatic step(bit e, bit r);
    @(posedge clk);
    if (reset_n && en) k++;
    #1;
    reset_n = r;
    en = e;
    if (!r) k = 0;
    push_all();
  endtask

  task automatic cmp(string tag, exp_t e, int pc, int lc, bit hs, bit vs, bit on, bit ls, bit fs);
    chk({tag, ".pixel_cnt"},   pc, e.pc);
    chk({tag, ".line_cnt"},    lc, e.lc);
    chk({tag, ".h_sync"},      int'(hs), int'(e.hs));
    chk({tag, ".v_sync"},      int'(vs), int'(e.vs));
    chk({tag, ".video_on"},    int'(on), int'(e.on));
    chk({tag, ".line_start"},  int'(ls), int'(e.ls));
    chk({tag, ".frame_start"}, int'(fs), int'(e.fs));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("u0", e, int'(p0), int'(l0), hs0, vs0, on0, ls0, fs0);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("u1", e, int'(p1), int'(l1), hs1, vs1, on1, ls1, fs1);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        cmp("u2", e, int'(p2), int'(l2), hs2, vs2, on2, ls2, fs2);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    int guard;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    // Continuous enable: covers several default lines and many small frames.
    for (int i = 0; i < 2600; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 4) != 0, 1'b1);

    // Freeze the small raster on its very last pixel, then resume into (0,0).
    guard = 0;
    while ((k % 176) != 175 && guard < 400) begin
      step(1'b1, 1'b1);
      guard++;
    end
    chk("reach_last_pixel_u0", k % 176, 175);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Mid-frame async reset must clear counters and blank without a clock edge.
    guard = 0;
    while ((k % 176) != 4 * 16 + 5 && guard < 400) begin
      step(1'b1, 1'b1);
      guard++;
    end
    chk("reach_mid_frame_u0", int'(p0) * 100 + int'(l0), 5 * 100 + 4);
    step(1'b0, 1'b0);
    #1;
    chk("async_rst.u0.pixel_cnt", int'(p0), 0);
    chk("async_rst.u0.line_cnt",  int'(l0), 0);
    chk("async_rst.u0.video_on",  int'(on0), 0);
    chk("async_rst.u1.video_on",  int'(on1), 0);
    chk("async_rst.u2.pixel_cnt", int'(p2), 0);
    chk("async_rst.u2.line_cnt",  int'(l2), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 400; i++) step($urandom_range(0, 3) != 0, 1'b1);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
